// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: password-gated parking entry with slot counting, timeout and lockout
module parking_gate_ctrl #(
  parameter int          CAPACITY    = 8,
  parameter logic [3:0]  PASSWORD    = 4'b1011,
  parameter int          PWD_TIMEOUT = 10,
  parameter int          MAX_TRIES   = 3,
  parameter int          LOCK_SECS   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       sensor_entry,
  input  logic       sensor_pass,
  input  logic       car_leave,
  input  logic [3:0] password,
  input  logic       pwd_valid,
  output logic       gate_open,
  output logic       green_led,
  output logic       red_led,
  output logic       alarm,
  output logic       full,
  output logic [3:0] free_slots,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT_PWD = 3'd1, OPEN = 3'd2, WRONG = 3'd3, LOCKED = 3'd4} state_t;
  localparam logic [3:0] CAP = 4'(CAPACITY);
  localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [7:0] PWD_T = 8'(PWD_TIMEOUT);
  localparam logic [7:0] LOCK_T = 8'(LOCK_SECS);
  state_t st, st_n;
  logic [7:0] sec, sec_n;
  logic [3:0] tries, tries_n, fs_n;
  logic dec, red_n;
  assign state = st;
  always_comb begin
    st_n = st;
    sec_n = sec;
    tries_n = tries;
    case (st)
      IDLE: if (sensor_entry && free_slots != 4'd0) begin
        st_n = WAIT_PWD;
        sec_n = 8'd0;
        tries_n = 4'd0;
      end
      WAIT_PWD: if (pwd_valid && password == PASSWORD) st_n = OPEN;
      else if (pwd_valid) begin
        tries_n = tries + 4'd1;
        st_n = (tries_n == TRIES_MAX) ? LOCKED : WRONG;
        sec_n = 8'd0;
      end else if (tick_1hz) begin
        sec_n = sec + 8'd1;
        st_n = (sec_n == PWD_T) ? IDLE : WAIT_PWD;
      end
      WRONG: if (tick_1hz) begin
        st_n = WAIT_PWD;
        sec_n = 8'd0;
      end
      OPEN: if (sensor_pass) st_n = IDLE;
      LOCKED: if (tick_1hz) begin
        sec_n = sec + 8'd1;
        if (sec_n == LOCK_T) begin
          st_n = IDLE;
          tries_n = 4'd0;
        end
      end
      default: st_n = IDLE;
    endcase
  end
  // A pass and a leave in the same cycle cancel out
  assign dec = st == OPEN && sensor_pass && free_slots != 4'd0;
  assign fs_n = (dec && car_leave) ? free_slots :
                dec ? free_slots - 4'd1 :
                (car_leave && free_slots < CAP) ? free_slots + 4'd1 : free_slots;
  // Lockout starts with the red LED lit, then blinks on the 2 Hz tick
  assign red_n = st_n == WRONG || (st_n == LOCKED && (st == LOCKED ? red_led ^ tick_2hz : 1'b1));
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      sec <= 8'd0;
      tries <= 4'd0;
      free_slots <= CAP;
      gate_open <= 1'b0;
      green_led <= 1'b0;
      red_led <= 1'b0;
      alarm <= 1'b0;
      full <= 1'b0;
    end else begin
      st <= st_n;
      sec <= sec_n;
      tries <= tries_n;
      free_slots <= fs_n;
      gate_open <= st_n == OPEN;
      green_led <= st_n == OPEN;
      red_led <= red_n;
      alarm <= st_n == LOCKED;
      full <= fs_n == 4'd0;
    end
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scoreboard bench for parking_gate_ctrl
module tb_parking_gate_ctrl;
  logic clk = 1'b0, reset = 1'b0, tick_1hz = 1'b0, tick_2hz = 1'b0;
  logic sensor_entry = 1'b0, sensor_pass = 1'b0, car_leave = 1'b0, pwd_valid = 1'b0;
  logic [3:0] password = 4'd0;
  logic gate_open, green_led, red_led, alarm, full;
  logic [3:0] free_slots;
  logic [2:0] state;
  typedef struct {string tag; logic [11:0] v;} exp_t;
  exp_t q[$];
  int n_vec = 0, n_bad = 0;
  logic r;
  int f;
  parking_gate_ctrl dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .sensor_entry(sensor_entry), .sensor_pass(sensor_pass), .car_leave(car_leave),
    .password(password), .pwd_valid(pwd_valid), .gate_open(gate_open), .green_led(green_led),
    .red_led(red_led), .alarm(alarm), .full(full), .free_slots(free_slots), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%0d gate=%b grn=%b red=%b alm=%b full=%b free=%0d, want st=%0d gate=%b grn=%b red=%b alm=%b full=%b free=%0d",
               tag, got[11:9], got[8], got[7], got[6], got[5], got[4], got[3:0],
               want[11:9], want[8], want[7], want[6], want[5], want[4], want[3:0]);
    end
  endtask
  // push expectation, clock once, pop and compare, then release pulse inputs
  task automatic cyc(input string tag, input logic [2:0] st, input logic [3:0] fs, input logic rd);
    exp_t e;
    e.tag = tag;
    e.v = {st, st == 3'd2, st == 3'd2, rd, st == 3'd4, fs == 4'd0, fs};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk(e.tag, {state, gate_open, green_led, red_led, alarm, full, free_slots}, e.v);
    {tick_1hz, tick_2hz, sensor_pass, car_leave, pwd_valid} = '0;
  endtask
  task automatic enter(input string tag, input logic [3:0] fs);
    sensor_entry = 1'b1;
    cyc(tag, 3'd1, fs, 1'b0);
    sensor_entry = 1'b0;
  endtask
  task automatic code(input logic [3:0] c);
    pwd_valid = 1'b1;
    password = c;
  endtask
  initial begin
    cyc("reset", 3'd0, 4'd8, 1'b0);
    reset = 1'b1;
    cyc("idle", 3'd0, 4'd8, 1'b0);
    enter("enter", 4'd8);
    code(4'b1011);
    cyc("pwd_ok", 3'd2, 4'd8, 1'b0);
    cyc("open_hold", 3'd2, 4'd8, 1'b0);
    sensor_pass = 1'b1;
    cyc("pass", 3'd0, 4'd7, 1'b0);
    enter("enter_to", 4'd7);
    for (int i = 0; i < 9; i++) begin
      tick_1hz = 1'b1;
      cyc("wait_tick", 3'd1, 4'd7, 1'b0);
    end
    tick_1hz = 1'b1;
    cyc("timeout", 3'd0, 4'd7, 1'b0);
    enter("enter_prio", 4'd7);
    for (int i = 0; i < 9; i++) begin
      tick_1hz = 1'b1;
      cyc("prio_tick", 3'd1, 4'd7, 1'b0);
    end
    tick_1hz = 1'b1;
    code(4'b1011);
    cyc("prio_ok", 3'd2, 4'd7, 1'b0);
    sensor_pass = 1'b1;
    car_leave = 1'b1;
    cyc("simul", 3'd0, 4'd7, 1'b0);
    sensor_pass = 1'b1;
    cyc("pass_idle", 3'd0, 4'd7, 1'b0);
    enter("enter_lk", 4'd7);
    for (int k = 0; k < 2; k++) begin
      code(4'b0000);
      cyc("wrong", 3'd3, 4'd7, 1'b1);
      code(4'b1011);
      cyc("wrong_ign", 3'd3, 4'd7, 1'b1);
      tick_1hz = 1'b1;
      cyc("wrong_clr", 3'd1, 4'd7, 1'b0);
    end
    code(4'b0110);
    cyc("lock", 3'd4, 4'd7, 1'b1);
    r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_2hz = 1'b1;
      r = ~r;
      cyc("blink", 3'd4, 4'd7, r);
    end
    for (int i = 0; i < 4; i++) begin
      tick_1hz = 1'b1;
      cyc("lock_tick", 3'd4, 4'd7, r);
    end
    tick_1hz = 1'b1;
    cyc("unlock", 3'd0, 4'd7, 1'b0);
    enter("enter_after", 4'd7);
    code(4'b0001);
    cyc("tries_clr", 3'd3, 4'd7, 1'b1);
    tick_1hz = 1'b1;
    cyc("retry", 3'd1, 4'd7, 1'b0);
    code(4'b0010);
    cyc("wrong2", 3'd3, 4'd7, 1'b1);
    tick_1hz = 1'b1;
    cyc("retry2", 3'd1, 4'd7, 1'b0);
    code(4'b0011);
    cyc("lock2", 3'd4, 4'd7, 1'b1);
    reset = 1'b0;
    tick_1hz = 1'b1;
    car_leave = 1'b1;
    cyc("rst_locked", 3'd0, 4'd8, 1'b0);
    reset = 1'b1;
    f = 8;
    for (int i = 0; i < 8; i++) begin
      enter("fill_enter", 4'(f));
      code(4'b1011);
      cyc("fill_open", 3'd2, 4'(f), 1'b0);
      sensor_pass = 1'b1;
      f--;
      cyc("fill_pass", 3'd0, 4'(f), 1'b0);
    end
    sensor_entry = 1'b1;
    cyc("full_stay", 3'd0, 4'd0, 1'b0);
    cyc("full_stay2", 3'd0, 4'd0, 1'b0);
    sensor_entry = 1'b0;
    car_leave = 1'b1;
    f = 1;
    cyc("leave", 3'd0, 4'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      car_leave = 1'b1;
      f = (f < 8) ? f + 1 : 8;
      cyc("leave_sat", 3'd0, 4'(f), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
